// File: rtl/sm_trace_buffer_if.sv
// Trace output stream: show-ahead head entry with valid/ready handshake.
interface sm_trace_buffer_if #(
  parameter int CYC_W = 16
);
  logic             trace_valid;
  logic             trace_ready;
  logic [CYC_W-1:0] trace_cycle;
  logic [31:0]      trace_pc;
  logic [31:0]      trace_instr;

  modport master (
    output trace_valid, trace_cycle, trace_pc, trace_instr,
    input  trace_ready
  );

  modport slave (
    input  trace_valid, trace_cycle, trace_pc, trace_instr,
    output trace_ready
  );
endinterface

// File: rtl/sm_trace_buffer.sv
// Execution-trace capture: stamps each CPU step into a FIFO, drains it as a
// stream, and freezes capture on a branch-to-self loop or cycle budget expiry.
module sm_trace_buffer #(
  parameter int DEPTH      = 16,
  parameter int CYC_W      = 16,
  parameter int MAX_CYCLES = 120,
  parameter int LOOP_LIMIT = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cpu_step,
  input  logic [31:0]            pc,
  input  logic [31:0]            instr,
  sm_trace_buffer_if.master      trace,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow,
  output logic                   loop_detect,
  output logic                   timeout,
  output logic                   stopped
);
  localparam int AW = $clog2(DEPTH);
  localparam int RW = $clog2(LOOP_LIMIT + 1);
  localparam logic [AW:0]      FULL      = (AW+1)'(DEPTH);
  localparam logic [RW-1:0]    REP_LIMIT = RW'(LOOP_LIMIT);
  localparam logic [CYC_W-1:0] CYC_SAT   = '1;
  localparam logic [CYC_W-1:0] CYC_LAST  = CYC_W'(MAX_CYCLES - 1);

  typedef struct packed {
    logic [CYC_W-1:0] cycle;
    logic [31:0]      pc;
    logic [31:0]      instr;
  } entry_t;

  entry_t           mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [CYC_W-1:0] cyc;
  logic [RW-1:0]    rep;
  logic [31:0]      last_pc;
  logic             last_pc_valid;
  logic             cap, pop, push, same_pc;

  assign stopped = loop_detect | timeout;
  assign cap     = cpu_step & ~stopped;
  assign pop     = trace.trace_valid & trace.trace_ready;
  // A full FIFO still takes a step when the head leaves in the same clock.
  assign push    = cap & ((count < FULL) | pop);
  assign same_pc = last_pc_valid & (pc == last_pc);

  assign trace.trace_valid = (count != '0);
  assign trace.trace_cycle = mem[rd_ptr].cycle;
  assign trace.trace_pc    = mem[rd_ptr].pc;
  assign trace.trace_instr = mem[rd_ptr].instr;

  // NOTE: storage is not reset; count gates every read, so stale words are never visible.
  always_ff @(posedge clk) begin
    if (!rst && push) begin
      mem[wr_ptr] <= '{cycle: cyc, pc: pc, instr: instr};
    end
  end

  // NOTE: non-blocking assignments throughout, so every term reads pre-edge state.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      cyc           <= '0;
      rep           <= '0;
      last_pc       <= '0;
      last_pc_valid <= 1'b0;
      overflow      <= 1'b0;
      loop_detect   <= 1'b0;
      timeout       <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;

      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;

      if (cap && !push) overflow <= 1'b1;

      if (cap) begin
        // Dropped steps still advance the stamp so gaps show downstream.
        if (cyc != CYC_SAT)  cyc     <= cyc + 1'b1;
        if (cyc == CYC_LAST) timeout <= 1'b1;

        last_pc       <= pc;
        last_pc_valid <= 1'b1;

        if (same_pc) begin
          if (rep != REP_LIMIT)             rep         <= rep + 1'b1;
          if (rep == REP_LIMIT - 1'b1)      loop_detect <= 1'b1;
        end else begin
          rep <= '0;
        end
      end
    end
  end
endmodule

// File: doc/sm_trace_buffer.md
Name: sm_trace_buffer

Overview:
- Execution-trace capture stage directly downstream of the sm_top debug port (regAddr = 0 returns the PC).
- Records one {cycle, pc, instr} entry per retired CPU cycle into a FIFO and drains it through a valid/ready stream to a UART or display formatter.
- Detects the branch-to-self halt idiom and a cycle-budget timeout, then freezes capture.
- Is the synthesizable on-board counterpart of the simulation trace printout.

Parameters:
DEPTH, 16, FIFO entries; power of two, >= 2
CYC_W, 16, width of the cycle stamp
MAX_CYCLES, 120, number of recorded steps after which timeout asserts; 1..2^CYC_W-1
LOOP_LIMIT, 4, consecutive repeated-PC steps that assert loop_detect; >= 1

Ports:
clk  in  1  system clock; the only clock
rst  in  1  synchronous reset, active-high
cpu_step  in  1  one-clk pulse per CPU cycle (CPU clock-enable strobe)
pc  in  32  current PC word address, sampled when cpu_step = 1
instr  in  32  current instruction, sampled when cpu_step = 1
trace_valid  out  1  head entry available
trace_ready  in  1  consumer accepts the head entry
trace_cycle  out  CYC_W  cycle stamp of the head entry
trace_pc  out  32  PC of the head entry
trace_instr  out  32  instruction of the head entry
count  out  $clog2(DEPTH)+1  current occupancy
overflow  out  1  sticky: at least one step was dropped because the FIFO was full
loop_detect  out  1  sticky: halt loop detected
timeout  out  1  sticky: MAX_CYCLES steps recorded
stopped  out  1  loop_detect | timeout

Behaviour:
- Reset (rst = 1 at a clk edge) clears:
  - pointers, count, cycle counter, repeat counter, last_pc_valid
  - overflow, loop_detect, timeout
  - All outputs read 0 after reset; trace_* data are don't-care while trace_valid = 0.
- Reset mid-operation discards all stored entries. A step or pop presented in the reset cycle is ignored.
- Capture enable: cap = cpu_step & ~stopped.
  - When stopped = 1, steps are ignored completely: no push, no counting, no overflow.
  - Popping continues while stopped.
- Cycle counter cyc:
  - Increments by 1 on every cap, whether or not the push succeeded.
  - The entry written carries the pre-increment value, so the first step is stamped 0.
  - Saturates at 2^CYC_W-1.
- Push:
  - Accepted when cap & (count < DEPTH | pop), where pop = trace_valid & trace_ready.
  - A simultaneous push and pop on a full FIFO succeeds and count stays DEPTH.
  - Entry is written at wr_ptr; wr_ptr wraps modulo DEPTH.
- Drop: cap while count = DEPTH and no pop sets overflow. The entry is lost, but cyc still increments, so the gap is visible in the stamps.
- Pop:
  - trace_valid = (count != 0).
  - trace_* come from the rd_ptr entry (show-ahead), stable while valid and not ready.
  - rd_ptr wraps modulo DEPTH.
  - Data pushed in cycle N is visible at the output in cycle N+1 when the FIFO was empty.
  - count: +1 on push only, -1 on pop only, unchanged on both.
- Loop detector:
  - On cap: if last_pc_valid & pc == last_pc, then rep <= rep+1; else rep <= 0.
  - Also on cap: last_pc <= pc and last_pc_valid <= 1.
  - loop_detect sets in the clk after the cap that brings rep to LOOP_LIMIT.
- Timeout: sets in the clk after the cap that makes cyc == MAX_CYCLES.
- The step that triggers loop_detect or timeout is itself pushed (subject to full). stopped rises the next clk.
- loop_detect and timeout may set in the same clk; both stay 1 until rst.

Test Plan:
- Reset, then 5 steps with pc = 0,1,2,3,4, instr = 0x24020001+k, trace_ready = 1:
  - 5 entries emerge in order, stamped 0..4.
  - First trace_valid appears 1 clk after the first step.
  - count returns to 0.
- trace_ready = 0, 20 steps with distinct pc:
  - count reaches 16 and overflow = 1.
  - Draining yields stamps 0..15.
  - A 21st step then reaches the FIFO with stamp 20.
- FIFO full, trace_ready = 1 and a step in the same clk:
  - count stays 16, overflow stays 0.
  - Popped stamp 0; newest entry has stamp 16.
- Steps with pc = 7,8,8,8,8,8 (LOOP_LIMIT = 4):
  - loop_detect = 1 one clk after the sixth step; all 6 entries stored.
  - A further step with pc = 9 is ignored (count unchanged, no new stamp).
- MAX_CYCLES = 10, pc incrementing, ready = 1:
  - timeout = 1 after the 10th step; last stamp 9.
  - Steps 11..15 produce nothing.
- 8 entries buffered and loop_detect = 1, then rst pulsed for 1 clk:
  - All outputs 0, count 0.
  - Next step is recorded with stamp 0.
